// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pkg: shared types and constants for the pipelined immediate generator.
//   imm_fmt_e    - immediate format code driven on out_fmt
//   skid_state_e - occupancy of the two-entry output skid buffer
//   imm_dec_t    - decode metadata (format + illegal flag) stored per entry
//   OPC_*        - RV32/RV64 base opcodes recognised by the decoder
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE   = 3'd0,
        FMT_ISHAMT = 3'd1,
        FMT_I      = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4,
        FMT_U      = 3'd5,
        FMT_J      = 3'd6
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    typedef struct packed {
        imm_fmt_e fmt;
        logic     illegal;
    } imm_dec_t;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // SLLI/SRLI/SRAI share the OP-IMM opcode; funct3 picks them out.
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: upstream (IF side) and downstream (EX side) handshake bundle.
//   in_valid/in_ready/in_instr/in_pc/in_tag        - instruction into the block
//   out_valid/out_ready/out_imm/out_fmt/
//   out_illegal/out_tag/out_target                 - decoded result out of the block
//   master - the environment (drives in_*, out_ready)
//   slave  - the immediate generator
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    imm_fmt_e         out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_target;

    modport master (
        output in_valid, in_instr, in_pc, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, out_target
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag, out_target
    );

endinterface

// File: rtl/imm_gen_pipe_decode.sv
// imm_gen_decode: purely combinational RISC-V immediate decode.
//   i_instr   in  32    raw instruction
//   o_imm     out XLEN  sign-extended immediate (shift amounts zero-extended)
//   o_fmt     out 3     format code
//   o_illegal out 1     opcode not recognised
// XLEN = 64 widens shift amounts to 6 bits and enables OP-IMM-32.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_e        o_fmt,
    output logic            o_illegal
);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [5:0]  w_shamt;
    logic [31:0] w_imm32;

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_shamt = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};

    always_comb begin
        w_imm32   = '0;
        o_fmt     = FMT_NONE;
        o_illegal = 1'b0;
        case (w_opc)
            OPC_OP_IMM: begin
                if (is_shift_f3(w_f3)) begin
                    o_fmt   = FMT_ISHAMT;
                    w_imm32 = {26'b0, w_shamt};
                end else begin
                    o_fmt   = FMT_I;
                    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                o_fmt   = FMT_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OPC_STORE: begin
                o_fmt   = FMT_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                o_fmt   = FMT_B;
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_fmt   = FMT_U;
                w_imm32 = {i_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                o_fmt   = FMT_J;
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
            OPC_OP: begin
                o_fmt = FMT_NONE;
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    // Word shifts only ever take a 5-bit shamt.
                    if (is_shift_f3(w_f3)) begin
                        o_fmt   = FMT_ISHAMT;
                        w_imm32 = {27'b0, i_instr[24:20]};
                    end else begin
                        o_fmt   = FMT_I;
                        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
                    end
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase

        o_imm       = {XLEN{w_imm32[31]}};
        o_imm[31:0] = w_imm32;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator between IF and EX.
//   Clk_CPU in  clock, rising edge
//   rstn    in  async active-low reset
//   flush   in  sync flush, drops every buffered entry and any same-cycle accept
//   bus     slave modport of imm_gen_pipe_if (valid/ready in, valid/ready out)
// One-cycle latency, one result per cycle, two-entry skid buffer (main + skid)
// so in_ready depends only on registered state.
// Build option: IMM_GEN_TARGET_EN adds a registered in_pc + imm branch/jump
// target for B, J and AUIPC; without it out_target is constant zero.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic           Clk_CPU,
    input  logic           rstn,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_dec_t         dec;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] w_imm;
    imm_fmt_e        w_fmt;
    logic            w_illegal;
    entry_t          w_new;

    skid_state_e     r_state;
    logic            r_in_ready;
    logic            r_out_valid;
    entry_t          r_main;
    entry_t          r_skid;

    logic            w_accept;
    logic            w_pop;
    logic            w_ld_main_new;
    logic            w_ld_main_skid;
    logic            w_ld_skid_new;

    imm_gen_decode #(.XLEN(XLEN)) u_decode (
        .i_instr   (bus.in_instr),
        .o_imm     (w_imm),
        .o_fmt     (w_fmt),
        .o_illegal (w_illegal)
    );

    assign w_new.imm         = w_imm;
    assign w_new.dec.fmt     = w_fmt;
    assign w_new.dec.illegal = w_illegal;
    assign w_new.tag         = bus.in_tag;

    // flush discards a same-cycle accept, so it is folded into w_accept.
    assign w_accept = bus.in_valid & r_in_ready & ~flush;
    assign w_pop    = r_out_valid & bus.out_ready;

    assign w_ld_main_new  = w_accept & ((r_state == SKID_EMPTY) |
                                        ((r_state == SKID_ONE) & w_pop));
    assign w_ld_skid_new  = w_accept & (r_state == SKID_ONE) & ~w_pop;
    assign w_ld_main_skid = (r_state == SKID_FULL) & w_pop & ~flush;

    // in_ready / out_valid are registered alongside the state so neither has
    // a combinational path from out_ready or in_valid.
    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_state     <= SKID_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= SKID_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (w_accept && !w_pop) begin
                        r_state    <= SKID_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_accept && w_pop) begin
                        r_state     <= SKID_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                SKID_FULL: begin
                    if (w_pop) begin
                        r_state    <= SKID_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= SKID_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_ld_main_new) begin
                r_main <= w_new;
            end else if (w_ld_main_skid) begin
                r_main <= r_skid;
            end
            if (w_ld_skid_new) begin
                r_skid <= w_new;
            end
        end
    end

`ifdef IMM_GEN_TARGET_EN
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] r_main_tgt;
    logic [XLEN-1:0] r_skid_tgt;

    // Wraps mod 2^XLEN by construction.
    assign w_target = ((w_fmt == FMT_B) || (w_fmt == FMT_J) ||
                       (bus.in_instr[6:0] == OPC_AUIPC)) ? (bus.in_pc + w_imm) : '0;

    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            r_main_tgt <= '0;
            r_skid_tgt <= '0;
        end else begin
            if (w_ld_main_new) begin
                r_main_tgt <= w_target;
            end else if (w_ld_main_skid) begin
                r_main_tgt <= r_skid_tgt;
            end
            if (w_ld_skid_new) begin
                r_skid_tgt <= w_target;
            end
        end
    end

    assign bus.out_target = r_main_tgt;
`else
    assign bus.out_target = '0;
`endif

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_imm     = r_main.imm;
    assign bus.out_fmt     = r_main.dec.fmt;
    assign bus.out_illegal = r_main.dec.illegal;
    assign bus.out_tag     = r_main.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed-vector bench for imm_gen_pipe at XLEN=32.
// Target expectations follow the IMM_GEN_TARGET_EN build option.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NVEC  = 12;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tgt;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    logic flush;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .Clk_CPU (clk),
        .rstn    (rstn),
        .flush   (flush),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_tgt(input int unsigned i);
`ifdef IMM_GEN_TARGET_EN
        return vecs[i].tgt;
`else
        return 32'h0;
`endif
    endfunction

    task automatic drive(input int unsigned i, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.in_instr = vecs[i].instr;
        bus.in_pc    = vecs[i].pc;
        bus.in_tag   = tag;
    endtask

    task automatic check_out(input string name, input int unsigned i, input logic [3:0] tag);
        check_eq({name, ".valid"}, 64'(bus.out_valid),   64'd1);
        check_eq({name, ".imm"},   64'(bus.out_imm),     64'(vecs[i].imm));
        check_eq({name, ".fmt"},   64'(bus.out_fmt),     64'(vecs[i].fmt));
        check_eq({name, ".ill"},   64'(bus.out_illegal), 64'(vecs[i].ill));
        check_eq({name, ".tag"},   64'(bus.out_tag),     64'(tag));
        check_eq({name, ".tgt"},   64'(bus.out_target),  64'(exp_tgt(i)));
    endtask

    // Single transaction from EMPTY: not visible before the edge, visible after one.
    task automatic run_vec(input int unsigned i);
        string name;
        name = $sformatf("v%0d", i);
        drive(i, 4'(i));
        bus.out_ready = 1'b1;
        check_eq({name, ".pre_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({name, ".pre_ready"}, 64'(bus.in_ready),  64'd1);
        tick();
        bus.in_valid = 1'b0;
        check_out(name, i, 4'(i));
        tick();
        check_eq({name, ".drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        //           instr           pc            imm           fmt   ill   target
        vecs[0]  = '{32'hFFF00093, 32'h00000000, 32'hFFFFFFFF, 3'd2, 1'b0, 32'h00000000}; // ADDI -1
        vecs[1]  = '{32'h00509093, 32'h00000004, 32'h00000005, 3'd1, 1'b0, 32'h00000000}; // SLLI 5
        vecs[2]  = '{32'h123450B7, 32'h00000008, 32'h12345000, 3'd5, 1'b0, 32'h00000000}; // LUI
        vecs[3]  = '{32'hFE000CE3, 32'h00000100, 32'hFFFFFFF8, 3'd4, 1'b0, 32'h000000F8}; // BEQ -8
        vecs[4]  = '{32'h0000007F, 32'h00000010, 32'h00000000, 3'd0, 1'b1, 32'h00000000}; // illegal
        vecs[5]  = '{32'h00112623, 32'h00000014, 32'h0000000C, 3'd3, 1'b0, 32'h00000000}; // SW 12
        vecs[6]  = '{32'h008000EF, 32'h00000020, 32'h00000008, 3'd6, 1'b0, 32'h00000028}; // JAL +8
        vecs[7]  = '{32'h002081B3, 32'h00000024, 32'h00000000, 3'd0, 1'b0, 32'h00000000}; // ADD
        vecs[8]  = '{32'hFFFFF117, 32'h00002000, 32'hFFFFF000, 3'd5, 1'b0, 32'h00001000}; // AUIPC, wraps
        vecs[9]  = '{32'h4030D093, 32'h00000030, 32'h00000003, 3'd1, 1'b0, 32'h00000000}; // SRAI 3
        vecs[10] = '{32'hFFC12083, 32'h00000034, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h00000000}; // LW -4
        vecs[11] = '{32'h0010809B, 32'h00000038, 32'h00000000, 3'd0, 1'b1, 32'h00000000}; // ADDIW on RV32

        rstn          = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        #1 rstn = 1'b0;
        #2;
        check_eq("rst.valid", 64'(bus.out_valid),   64'd0);
        check_eq("rst.ready", 64'(bus.in_ready),    64'd1);
        check_eq("rst.imm",   64'(bus.out_imm),     64'd0);
        check_eq("rst.fmt",   64'(bus.out_fmt),     64'd0);
        check_eq("rst.ill",   64'(bus.out_illegal), 64'd0);
        check_eq("rst.tag",   64'(bus.out_tag),     64'd0);
        check_eq("rst.tgt",   64'(bus.out_target),  64'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        for (int unsigned i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // Back-to-back stream with the consumer stalled for three cycles.
        begin
            int unsigned sent;
            int unsigned got;
            sent = 0;
            got  = 0;
            bus.out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
                drive(sent, 4'(sent + 8));
                if (bus.in_ready) sent++;
                tick();
                check_eq($sformatf("stall%0d.imm", c), 64'(bus.out_imm), 64'(vecs[0].imm));
            end
            check_eq("stall.accepted", 64'(sent), 64'd2);
            check_eq("stall.in_ready", 64'(bus.in_ready), 64'd0);
            check_eq("stall.valid",    64'(bus.out_valid), 64'd1);

            for (int c = 0; c < 40 && got < 5; c++) begin
                bus.out_ready = 1'b1;
                if (sent < 5) drive(sent, 4'(sent + 8));
                else          bus.in_valid = 1'b0;
                if (bus.out_valid) begin
                    check_eq($sformatf("strm%0d.imm", got), 64'(bus.out_imm), 64'(vecs[got].imm));
                    check_eq($sformatf("strm%0d.tag", got), 64'(bus.out_tag), 64'(got + 8));
                    got++;
                end
                if (sent < 5 && bus.in_ready) sent++;
                tick();
            end
            bus.in_valid = 1'b0;
            check_eq("strm.count", 64'(got), 64'd5);
            check_eq("strm.empty", 64'(bus.out_valid), 64'd0);
        end

        // Flush from FULL with a pending input and a ready consumer.
        bus.out_ready = 1'b0;
        drive(5, 4'h1);
        tick();
        drive(6, 4'h2);
        tick();
        check_eq("full.in_ready", 64'(bus.in_ready), 64'd0);
        drive(7, 4'h3);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flushF.valid", 64'(bus.out_valid), 64'd0);
        check_eq("flushF.ready", 64'(bus.in_ready),  64'd1);
        tick();
        check_eq("flushF.absent", 64'(bus.out_valid), 64'd0);

        // Flush from ONE while an input would otherwise be accepted.
        bus.out_ready = 1'b0;
        drive(5, 4'h4);
        tick();
        drive(8, 4'h5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flushO.valid", 64'(bus.out_valid), 64'd0);
        tick();
        check_eq("flushO.absent", 64'(bus.out_valid), 64'd0);
        run_vec(3);

        // Asynchronous reset with the buffer full.
        bus.out_ready = 1'b0;
        drive(3, 4'h6);
        tick();
        drive(6, 4'h7);
        tick();
        bus.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_eq("arst.valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst.ready", 64'(bus.in_ready),  64'd1);
        check_eq("arst.imm",   64'(bus.out_imm),   64'd0);
        check_eq("arst.tag",   64'(bus.out_tag),   64'd0);
        tick();
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check_eq("arst.after", 64'(bus.out_valid), 64'd0);
        run_vec(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
